// File: rtl/arbitro_rr_ctrl_if.sv
// Bus between the switch controller and its FIFOs.
//   in_empty  : empty flags of input FIFOs 0..3
//   in_data   : head words of the input FIFOs (FWFT); FIFO i at [i*DW +: DW]
//   out_afull : almost-full flags of output FIFOs 4..7 (bit 0 = FIFO4)
//   pop       : pop strobes to the input FIFOs
//   push      : push strobes to the output FIFOs
//   data_out  : word presented with push
// master = controller side, slave = FIFO side.
interface arbitro_rr_ctrl_if #(
  parameter int DW = 10
);
  logic [3:0]      in_empty;
  logic [4*DW-1:0] in_data;
  logic [3:0]      out_afull;
  logic [3:0]      pop;
  logic [3:0]      push;
  logic [DW-1:0]   data_out;

  modport master (
    input  in_empty, in_data, out_afull,
    output pop, push, data_out
  );

  modport slave (
    output in_empty, in_data, out_afull,
    input  pop, push, data_out
  );
endinterface

// File: rtl/arbitro_rr_ctrl.sv
// Control and round-robin arbitration for the 4-in / 4-out FIFO switch.
// Sequences reset/init/active phases, latches the FIFO thresholds and moves
// one word per cycle from an input FIFO to the output FIFO named by the top
// two bits of the word, skipping words whose destination is almost full.
//
// Ports:
//   clk, reset             : clock, synchronous active-high reset
//   init                   : enter / hold configuration phase
//   limit_low, limit_high  : threshold requests, latched while in INIT
//   bus                    : FIFO-side signals (see arbitro_rr_ctrl_if)
//   limit_low_out/high_out : latched thresholds, fanned out to all FIFOs
//   state                  : one-hot phase
//   idle                   : high in IDLE
//   cfg_err                : sticky limit_low >= limit_high flag
//
// state  | meaning
// -------+-------------------------------------------------------
// RESET  | 0001, held while reset is high
// INIT   | 0010, thresholds follow limit_low/limit_high
// IDLE   | 0100, all inputs empty, waiting for traffic
// ACTIVE | 1000, arbitrating and moving words
module arbitro_rr_ctrl #(
  parameter int DW       = 10,
  parameter int LW       = 3,
  parameter int LOW_DEF  = 1,
  parameter int HIGH_DEF = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          init,
  input  logic [LW-1:0] limit_low,
  input  logic [LW-1:0] limit_high,
  arbitro_rr_ctrl_if.master bus,
  output logic [LW-1:0] limit_low_out,
  output logic [LW-1:0] limit_high_out,
  output logic [3:0]    state,
  output logic          idle,
  output logic          cfg_err
);

  typedef enum logic [3:0] {
    S_RESET  = 4'b0001,
    S_INIT   = 4'b0010,
    S_IDLE   = 4'b0100,
    S_ACTIVE = 4'b1000
  } state_t;

  localparam logic [LW-1:0] LOW_RST  = LW'(LOW_DEF);
  localparam logic [LW-1:0] HIGH_RST = LW'(HIGH_DEF);

  state_t        state_q, state_d;
  logic [1:0]    ptr_q;
  logic [3:0]    push_q;
  logic [DW-1:0] data_q;

  logic [DW-1:0] word [4];
  logic [1:0]    dest [4];
  logic [3:0]    cand;
  logic          arb_en;
  logic          grant_v;
  logic [1:0]    grant_idx;
  logic [1:0]    scan_idx;

  assign arb_en = (state_q == S_ACTIVE) && !init && !reset;

  // Candidate = non-empty input whose destination is not almost full.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      word[i] = bus.in_data[i*DW +: DW];
      dest[i] = word[i][DW-1 -: 2];
      cand[i] = !bus.in_empty[i] && !bus.out_afull[dest[i]];
    end
  end

  // First candidate at or after ptr, wrapping mod 4.
  always_comb begin
    grant_v   = 1'b0;
    grant_idx = 2'd0;
    scan_idx  = 2'd0;
    for (int k = 0; k < 4; k++) begin
      scan_idx = ptr_q + 2'(k);
      if (arb_en && !grant_v && cand[scan_idx]) begin
        grant_v   = 1'b1;
        grant_idx = scan_idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET:  state_d = S_INIT;
      S_INIT:   if (!init) state_d = S_IDLE;
      S_IDLE: begin
        if (init)                       state_d = S_INIT;
        else if (bus.in_empty != 4'hF)  state_d = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (init)                                  state_d = S_INIT;
        else if (bus.in_empty == 4'hF && !grant_v) state_d = S_IDLE;
      end
      default:  state_d = S_RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_RESET;
      ptr_q          <= 2'd0;
      push_q         <= 4'd0;
      data_q         <= '0;
      limit_low_out  <= LOW_RST;
      limit_high_out <= HIGH_RST;
      cfg_err        <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant_v) begin
        ptr_q  <= grant_idx + 2'd1;
        push_q <= 4'b0001 << dest[grant_idx];
        data_q <= word[grant_idx];
      end else begin
        push_q <= 4'd0;
      end
      if (state_q == S_INIT) begin
        limit_low_out  <= limit_low;
        limit_high_out <= limit_high;
        // Compare the values being latched on this same exit edge.
        if (!init) cfg_err <= (limit_low >= limit_high);
      end else if (state_d == S_INIT) begin
        cfg_err <= 1'b0;
      end
    end
  end

  // Gating with reset drops an in-flight word in the reset cycle itself.
  assign bus.pop      = grant_v ? (4'b0001 << grant_idx) : 4'd0;
  assign bus.push     = reset ? 4'd0 : push_q;
  assign bus.data_out = data_q;
  assign state        = state_q;
  assign idle         = (state_q == S_IDLE);

endmodule

// File: tb/tb_arbitro_rr_ctrl.sv
module tb_arbitro_rr_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       init;
  logic [2:0] limit_low, limit_high;
  logic [2:0] limit_low_out, limit_high_out;
  logic [3:0] state;
  logic       idle, cfg_err;

  arbitro_rr_ctrl_if #(.DW(10)) bus_if ();

  arbitro_rr_ctrl #(.DW(10), .LW(3), .LOW_DEF(1), .HIGH_DEF(6)) dut (
    .clk(clk), .reset(reset), .init(init),
    .limit_low(limit_low), .limit_high(limit_high),
    .bus(bus_if),
    .limit_low_out(limit_low_out), .limit_high_out(limit_high_out),
    .state(state), .idle(idle), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: phase 0=RESET 1=INIT 2=IDLE 3=ACTIVE
  int         m_phase;
  int         m_ptr;
  logic [3:0] m_push;
  logic [9:0] m_dout;
  logic [2:0] m_ll, m_lh;
  logic       m_cfg;
  logic [9:0] fifo_q [4][$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_ptr = 0; m_push = 4'd0; m_dout = 10'd0;
    m_ll = 3'd1; m_lh = 3'd6; m_cfg = 1'b0;
  endtask

  function automatic int head_dest(int i);
    logic [9:0] w;
    w = fifo_q[i][0];
    return int'(w[9:8]);
  endfunction

  // One clock: drive FIFO view at negedge, check, then advance model at posedge.
  task automatic step();
    int g;
    int i;
    logic [3:0] exp_pop;
    @(negedge clk);
    for (int j = 0; j < 4; j++) begin
      bus_if.in_empty[j] = (fifo_q[j].size() == 0);
      bus_if.in_data[j*10 +: 10] = (fifo_q[j].size() != 0) ? fifo_q[j][0] : 10'($urandom);
    end
    #1;
    g = -1;
    if (!reset && m_phase == 3 && !init)
      for (int k = 0; k < 4; k++) begin
        i = (m_ptr + k) % 4;
        if (g < 0 && fifo_q[i].size() != 0 && !bus_if.out_afull[head_dest(i)]) g = i;
      end
    exp_pop = (g >= 0) ? 4'(1 << g) : 4'd0;
    chk("pop", 32'(bus_if.pop), 32'(exp_pop));
    chk("push", 32'(bus_if.push), reset ? 32'd0 : 32'(m_push));
    chk("data_out", 32'(bus_if.data_out), 32'(m_dout));
    chk("state", 32'(state), 32'(1 << m_phase));
    chk("idle", 32'(idle), 32'(m_phase == 2));
    chk("cfg_err", 32'(cfg_err), 32'(m_cfg));
    chk("limit_low_out", 32'(limit_low_out), 32'(m_ll));
    chk("limit_high_out", 32'(limit_high_out), 32'(m_lh));
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      if (g >= 0) begin
        m_push = 4'(1 << head_dest(g));
        m_dout = fifo_q[g].pop_front();
        m_ptr  = (g + 1) % 4;
      end else begin
        m_push = 4'd0;
      end
      case (m_phase)
        0: m_phase = 1;
        1: begin
          m_ll = limit_low; m_lh = limit_high;
          if (!init) begin m_phase = 2; m_cfg = (limit_low >= limit_high); end
        end
        2: begin
          if (init) begin m_phase = 1; m_cfg = 1'b0; end
          else if (bus_if.in_empty != 4'hF) m_phase = 3;
        end
        default: begin
          if (init) begin m_phase = 1; m_cfg = 1'b0; end
          else if (bus_if.in_empty == 4'hF && g < 0) m_phase = 2;
        end
      endcase
    end
    #1;
  endtask

  task automatic configure(input logic [2:0] ll, input logic [2:0] lh, input int n);
    init = 1'b1; limit_low = ll; limit_high = lh;
    repeat (n) step();
    init = 1'b0;
    step();
  endtask

  initial begin
    int init_hold;
    reset = 1'b1; init = 1'b0; limit_low = 3'd0; limit_high = 3'd0;
    bus_if.in_empty = 4'hF; bus_if.in_data = '0; bus_if.out_afull = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    step();

    // Bring-up with good thresholds
    reset = 1'b0;
    configure(3'd3, 3'd6, 4);
    repeat (2) step();

    // Bad thresholds set the sticky error; re-entering INIT clears it
    configure(3'd5, 3'd2, 3);
    repeat (3) step();
    configure(3'd3, 3'd6, 2);

    // Four simultaneous requests, one per destination
    fifo_q[0].push_back(10'h0AA); fifo_q[1].push_back(10'h155);
    fifo_q[2].push_back(10'h2CC); fifo_q[3].push_back(10'h333);
    repeat (8) step();

    // Stalled head on input 0 must not block input 1
    fifo_q[0].push_back({2'b10, 8'h11});
    for (int j = 0; j < 6; j++) fifo_q[1].push_back({2'b01, 8'(j)});
    bus_if.out_afull = 4'b0100;
    repeat (6) step();
    bus_if.out_afull = 4'b0000;
    repeat (8) step();

    // Reset right after a grant drops the in-flight word
    for (int j = 0; j < 4; j++) fifo_q[j].push_back(10'($urandom));
    repeat (2) step();
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    configure(3'd2, 3'd5, 2);

    // Drain to IDLE, then init during ACTIVE with a push pending
    fifo_q[2].push_back(10'h1F0); fifo_q[3].push_back(10'h0F3);
    repeat (5) step();
    for (int j = 0; j < 4; j++) fifo_q[j].push_back(10'($urandom));
    repeat (2) step();
    init = 1'b1;
    repeat (3) step();
    init = 1'b0;
    repeat (8) step();

    // Randomized traffic
    init_hold = 0;
    for (int c = 0; c < 500; c++) begin
      if ($urandom_range(0, 99) < 45) begin
        int qi;
        qi = $urandom_range(0, 3);
        if (fifo_q[qi].size() < 4) fifo_q[qi].push_back(10'($urandom));
      end
      for (int b = 0; b < 4; b++) bus_if.out_afull[b] = ($urandom_range(0, 3) == 0);
      if (init_hold > 0) begin
        init = 1'b1; init_hold--;
      end else if ($urandom_range(0, 39) == 0) begin
        init = 1'b1; init_hold = $urandom_range(1, 3);
        limit_low = 3'($urandom); limit_high = 3'($urandom);
      end else begin
        init = 1'b0;
      end
      reset = ($urandom_range(0, 149) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/arbitro_rr_ctrl.md
Name: arbitro_rr_ctrl

Overview:
Main control and arbitration block for the 4-input / 4-output FIFO switch. Sequences reset, init and active phases, and latches the almost-empty/almost-full thresholds that configure all FIFOs. Arbitrates round-robin among the 4 input FIFOs. Moves one 10-bit word per cycle to the output FIFO selected by bits [9:8] of that word, stalling any word whose destination is almost full.

Parameters:
DW, 10, data word width; bits [DW-1:DW-2] carry the destination index
LW, 3, threshold width
LOW_DEF, 1, limit_low reset value
HIGH_DEF, 6, limit_high reset value

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
init  in  1  enter or hold configuration phase
limit_low  in  LW  almost-empty threshold request
limit_high  in  LW  almost-full threshold request
in_empty  in  4  empty flags, input FIFOs 0..3
in_data  in  4*DW  head words of the first-word-fall-through input FIFOs; FIFO i occupies [i*DW +: DW]
out_afull  in  4  almost-full flags, output FIFOs 4..7 (bit 0 = FIFO4)
pop  out  4  pop strobes to input FIFOs
push  out  4  push strobes to output FIFOs
data_out  out  DW  word presented with push
limit_low_out  out  LW  latched almost-empty threshold, to all FIFOs
limit_high_out  out  LW  latched almost-full threshold, to all FIFOs
state  out  4  one-hot state: RESET=0001, INIT=0010, IDLE=0100, ACTIVE=1000
idle  out  1  high in IDLE
cfg_err  out  1  sticky configuration error

Behaviour:
- Reset, synchronous and dominant over every other input. Outputs and registers take:
  - state=RESET, pop=0, push=0, data_out=0
  - limit_low_out=LOW_DEF, limit_high_out=HIGH_DEF
  - idle=0, cfg_err=0
  - round-robin pointer ptr=0, push pipeline register cleared. An in-flight word is dropped; no push occurs in the cycle after reset.
- State transitions, all registered:
  - RESET -> INIT on the first edge with reset=0.
  - INIT: limit_low_out/limit_high_out <= limit_low/limit_high every cycle. INIT -> IDLE when init=0.
  - On INIT exit, cfg_err <= (latched limit_low >= latched limit_high). cfg_err clears only on reset or on re-entry to INIT.
  - IDLE -> ACTIVE when in_empty != 4'hF. IDLE -> INIT if init=1.
  - ACTIVE -> IDLE when in_empty == 4'hF and no grant is made this cycle. ACTIVE -> INIT if init=1.
- Arbitration, combinational, only in ACTIVE with init=0:
  - Candidate i exists when in_empty[i]=0 and out_afull[dest_i]=0, where dest_i = in_data[i*DW+DW-1 -: 2].
  - Grant goes to the first candidate searching from ptr upward, mod 4. At most one grant per cycle.
  - pop[g]=1 in the same cycle as the grant.
  - On a grant, ptr <= g+1 mod 4. With no candidate, ptr holds and pop=0.
  - cfg_err does not block arbitration.
- Push path, 1-cycle latency: in the cycle after grant g, push[dest_g]=1 and data_out = the granted word, unmodified. Otherwise push=0 and data_out holds its last value.
- A pending push still completes in the cycle after an ACTIVE->INIT or ACTIVE->IDLE transition.
- Flow control: out_afull is sampled before the in-flight push lands. Output FIFOs must assert almost-full at occupancy >= limit_high_out, and software keeps limit_high <= depth-2 so no overflow occurs.
- Blocked heads: a stalled word at the head of FIFO i never blocks other FIFOs. The search skips i until its destination clears.
- Simultaneous requests: when all 4 inputs request continuously with free destinations, grants cycle 0,1,2,3,0,... starting from ptr.

Test Plan:
1. Reset, then init=1 for 3 cycles with limit_low=3, limit_high=6 -> state 0001 -> 0010 -> 0100 after init drops; limit_low_out=3, limit_high_out=6; cfg_err=0.
2. INIT with limit_low=5, limit_high=2, then init=0 -> cfg_err=1 from the next cycle and stays 1 until init or reset.
3. All 4 inputs non-empty, heads 10'h0AA, 10'h155, 10'h2CC, 10'h333, out_afull=0 -> pops 0,1,2,3 on consecutive cycles; push[0],[1],[2],[3] each one cycle later with matching data_out.
4. Input 0 head dest=2 with out_afull[2]=1, input 1 head dest=1 -> input 0 never popped and input 1 served every cycle. After out_afull[2] drops, input 0 is granted within 4 cycles.
5. Grant issued, reset=1 in the next cycle -> push=0 in that cycle and after; state=0001; ptr=0.
6. Last word popped, inputs now empty -> state returns to 0100 and idle=1. init=1 during ACTIVE -> no pop while init=1; the pending push still appears.
